flit_priority_gen: RTL

Registered priority-tagging stage directly upstream of the 4-to-1 output arbiters in the MinBD router. Each cycle it takes up to four incoming flit headers and marks each one golden or silver: golden comes from the network-wide rotating epoch, silver is one random pick per cycle. It also generates the 2-bit random tie-break value. It then presents `vld_vec`, `gold_vec`, `silver_vec`, `flit_id_vec` and `rand_num` to the arbiters one cycle later.

---
 rtl/flit_priority_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/flit_priority_gen.sv
// flit_priority_gen
//
// Registered priority-tagging stage that sits in front of the 4-to-1 output arbiters.
// Each cycle it takes up to four incoming flit headers and tags each one:
//   - golden: the header matches the network-wide rotating golden (source, packet id);
//   - silver: at most one non-golden valid flit, picked by an LFSR-rotated scan.
// It also registers a 2-bit random tie-break value. Everything appears one cycle later.
//
// Optional feature macro: MINBD_SILVER_EN. When it is defined, silver selection is built.
// When it is undefined, silver_vec stays 0, but the LFSR still runs and drives rand_num.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_vld       in   [3:0] per-port flit valid
//   in_src       in   [4*NODE_BITS-1:0] per-port source node id (port i at [i*NODE_BITS +:])
//   in_pktid     in   [4*PKTID_BITS-1:0] per-port packet sequence id
//   in_flit_id   in   [4*WIDTH_PKTSZ-1:0] per-port flit index within its packet
//   vld_vec      out  [3:0] registered valid
//   gold_vec     out  [3:0] registered golden flags
//   silver_vec   out  [3:0] registered silver flags (one-hot or zero)
//   flit_id_vec  out  [4*WIDTH_PKTSZ-1:0] registered flit ids (0 in invalid slots)
//   rand_num     out  [1:0] registered LFSR low bits, used for arbiter tie-break
//   golden_src   out  current golden source node (debug)
//   golden_pkt   out  current golden packet id (debug)

`ifndef WIDTH_PKTSZ
`define WIDTH_PKTSZ 3
`endif

module flit_priority_gen #(
  parameter int unsigned EPOCH_LEN  = 64,
  parameter int unsigned NUM_NODE   = 16,
  parameter int unsigned NODE_BITS  = 4,
  parameter int unsigned PKTID_BITS = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  in_vld,
  input  logic [4*NODE_BITS-1:0]      in_src,
  input  logic [4*PKTID_BITS-1:0]     in_pktid,
  input  logic [4*`WIDTH_PKTSZ-1:0]   in_flit_id,
  output logic [3:0]                  vld_vec,
  output logic [3:0]                  gold_vec,
  output logic [3:0]                  silver_vec,
  output logic [4*`WIDTH_PKTSZ-1:0]   flit_id_vec,
  output logic [1:0]                  rand_num,
  output logic [NODE_BITS-1:0]        golden_src,
  output logic [PKTID_BITS-1:0]       golden_pkt
);

  localparam int unsigned FidBits   = `WIDTH_PKTSZ;
  localparam int unsigned EpochBits = $clog2(EPOCH_LEN);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SeedEff   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // State registers
  logic [EpochBits-1:0]  r_epoch_cnt;
  logic [NODE_BITS-1:0]  r_golden_src;
  logic [PKTID_BITS-1:0] r_golden_pkt;
  logic [15:0]           r_lfsr;
  logic [3:0]            r_vld;
  logic [3:0]            r_gold;
  logic [3:0]            r_silver;
  logic [4*FidBits-1:0]  r_fid;
  logic [1:0]            r_rand;

  // Next-state / combinational values
  logic                  w_epoch_wrap;
  logic                  w_pkt_wrap;
  logic [EpochBits-1:0]  w_epoch_cnt_d;
  logic [NODE_BITS-1:0]  w_golden_src_d;
  logic [PKTID_BITS-1:0] w_golden_pkt_d;
  logic [15:0]           w_lfsr_d;
  logic [3:0]            w_gold;
  logic [3:0]            w_silver;
  logic [4*FidBits-1:0]  w_fid;

  // Epoch rotation: the packet id steps on every epoch wrap, and the source steps
  // when the packet id itself wraps.
  always_comb begin
    w_epoch_wrap   = (r_epoch_cnt == EpochBits'(EPOCH_LEN - 1));
    w_pkt_wrap     = w_epoch_wrap && (r_golden_pkt == {PKTID_BITS{1'b1}});
    w_epoch_cnt_d  = w_epoch_wrap ? '0 : r_epoch_cnt + EpochBits'(1);
    w_golden_pkt_d = w_epoch_wrap ? r_golden_pkt + PKTID_BITS'(1) : r_golden_pkt;
    w_golden_src_d = r_golden_src;
    if (w_pkt_wrap) begin
      w_golden_src_d = (r_golden_src == NODE_BITS'(NUM_NODE - 1)) ? '0
                                                                   : r_golden_src + NODE_BITS'(1);
    end
  end

  // Fibonacci LFSR, taps 16/14/13/11
  always_comb begin
    w_lfsr_d = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Gold tagging against the golden id held before this edge; invalid slots are zeroed.
  always_comb begin
    w_gold = '0;
    w_fid  = '0;
    for (int i = 0; i < 4; i++) begin
      w_gold[i] = in_vld[i]
                  && (in_src[i*NODE_BITS +: NODE_BITS] == r_golden_src)
                  && (in_pktid[i*PKTID_BITS +: PKTID_BITS] == r_golden_pkt);
      w_fid[i*FidBits +: FidBits] = in_vld[i] ? in_flit_id[i*FidBits +: FidBits] : '0;
    end
  end

`ifdef MINBD_SILVER_EN
  logic [3:0] w_cand;
  logic [1:0] w_idx;

  // Rotating-priority scan starting at lfsr[3:2]; first non-golden valid port wins.
  always_comb begin
    w_cand   = in_vld & ~w_gold;
    w_silver = '0;
    w_idx    = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_lfsr[3:2] + 2'(k);
      if (w_cand[w_idx] && (w_silver == 4'b0000)) begin
        w_silver[w_idx] = 1'b1;
      end
    end
  end
`else
  assign w_silver = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_epoch_cnt  <= '0;
      r_golden_src <= '0;
      r_golden_pkt <= '0;
      r_lfsr       <= SeedEff;
      r_vld        <= '0;
      r_gold       <= '0;
      r_silver     <= '0;
      r_fid        <= '0;
      r_rand       <= SeedEff[1:0];
    end else begin
      r_epoch_cnt  <= w_epoch_cnt_d;
      r_golden_src <= w_golden_src_d;
      r_golden_pkt <= w_golden_pkt_d;
      r_lfsr       <= w_lfsr_d;
      r_vld        <= in_vld;
      r_gold       <= w_gold;
      r_silver     <= w_silver;
      r_fid        <= w_fid;
      r_rand       <= r_lfsr[1:0];
    end
  end

  assign vld_vec     = r_vld;
  assign gold_vec    = r_gold;
  assign silver_vec  = r_silver;
  assign flit_id_vec = r_fid;
  assign rand_num    = r_rand;
  assign golden_src  = r_golden_src;
  assign golden_pkt  = r_golden_pkt;

endmodule
